// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter
//   Collects one-cycle spike pulses from NUM_NEURONS neurons, timestamps each
//   spike on arrival, and emits them one at a time as (addr, time) events over
//   a valid/ready handshake. Neurons are served round-robin. A spike that
//   arrives while the same neuron still holds an unsent event is dropped and
//   counted.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   spike_in[N]         one-cycle spike pulses, one bit per neuron
//   ev_valid/ev_ready   output event handshake
//   ev_addr, ev_time    neuron index and arrival timestamp of the event
//   drop_count          saturating count of dropped spikes
//   overflow            sticky, set on the first dropped spike

// Per-neuron slot: pending bit plus captured timestamp.
module spike_lane #(
  parameter int TIME_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spike,
  input  logic                  grant,
  input  logic [TIME_WIDTH-1:0] time_now,
  output logic                  pending,
  output logic [TIME_WIDTH-1:0] ts,
  output logic                  drop
);
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      ts      <= '0;
    end else if (spike && (!pending || grant)) begin
      // Slot is free, or is being emptied by the grant this same cycle.
      pending <= 1'b1;
      ts      <= time_now;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

  assign drop = spike && pending && !grant;
endmodule

module spike_event_arbiter #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int TIME_WIDTH  = 16,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [ADDR_WIDTH-1:0]  ev_addr,
  output logic [TIME_WIDTH-1:0]  ev_time,
  output logic [DROP_WIDTH-1:0]  drop_count,
  output logic                   overflow
);
  localparam int CW = $clog2(NUM_NEURONS + 1);
  localparam int SW = ((DROP_WIDTH > CW) ? DROP_WIDTH : CW) + 1;
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  logic [TIME_WIDTH-1:0]                  time_cnt;
  logic [NUM_NEURONS-1:0]                 pending;
  logic [NUM_NEURONS-1:0]                 drop;
  logic [NUM_NEURONS-1:0]                 grant;
  logic [NUM_NEURONS-1:0][TIME_WIDTH-1:0] ts;
  logic [ADDR_WIDTH-1:0]                  rr_ptr;
  logic [ADDR_WIDTH-1:0]                  gnt_idx;
  logic [ADDR_WIDTH-1:0]                  rr_next;
  logic                                   found;
  logic                                   loadable;
  logic                                   load_en;
  logic [CW-1:0]                          drop_n;
  logic [SW-1:0]                          drop_sum;

  // Output slot is free when empty or being drained this cycle.
  assign loadable = !ev_valid || ev_ready;
  assign load_en  = loadable && found;

  // Round-robin search: first pending index at or above rr_ptr, wrapping.
  always_comb begin
    int j;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_NEURONS) j = j - NUM_NEURONS;
      if (!found && pending[j]) begin
        found   = 1'b1;
        gnt_idx = ADDR_WIDTH'(j);
      end
    end
  end

  assign rr_next = (gnt_idx == ADDR_WIDTH'(NUM_NEURONS - 1)) ? '0
                                                             : gnt_idx + ADDR_WIDTH'(1);

  generate
    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
      assign grant[i] = load_en && (gnt_idx == ADDR_WIDTH'(i));
      spike_lane #(.TIME_WIDTH(TIME_WIDTH)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .spike    (spike_in[i]),
        .grant    (grant[i]),
        .time_now (time_cnt),
        .pending  (pending[i]),
        .ts       (ts[i]),
        .drop     (drop[i])
      );
    end
  endgenerate

  // Several neurons can drop in the same cycle; each one counts.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_NEURONS; i++) drop_n = drop_n + CW'(drop[i]);
    drop_sum = SW'(drop_count) + SW'(drop_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_cnt   <= '0;
      rr_ptr     <= '0;
      ev_valid   <= 1'b0;
      ev_addr    <= '0;
      ev_time    <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      time_cnt <= time_cnt + TIME_WIDTH'(1);
      if (load_en) begin
        ev_valid <= 1'b1;
        ev_addr  <= gnt_idx;
        ev_time  <= ts[gnt_idx];
        rr_ptr   <= rr_next;
      end else if (loadable) begin
        ev_valid <= 1'b0;
      end
      if (|drop) begin
        overflow   <= 1'b1;
        drop_count <= (drop_sum > SW'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_WIDTH-1:0];
      end
    end
  end
endmodule
